// File: rtl/lbp_scan_ctrl_if.sv
// Bus bundle for lbp_scan_ctrl: gray-memory read port plus LBP write port.
// master = the scan controller, slave = the host memories.
interface lbp_scan_ctrl_if #(
  parameter int ADDR_W = 14
);
  logic              gray_ready;
  logic [7:0]        gray_data;
  logic              gray_req;
  logic [ADDR_W-1:0] gray_addr;
  logic              lbp_valid;
  logic [ADDR_W-1:0] lbp_addr;
  logic [7:0]        lbp_data;
  logic              finish;

  modport master (
    input  gray_ready, gray_data,
    output gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish
  );

  modport slave (
    output gray_ready, gray_data,
    input  gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish
  );
endinterface

// File: rtl/lbp_scan_ctrl.sv
// lbp_scan_ctrl: streaming LBP scheduler over an IMG_W x IMG_W 8-bit image.
// Fetches each interior pixel's 3x3 window (column-major, top/mid/bottom),
// then writes the 8-bit LBP code for the centre. No frame buffer.
// Optional feature macro LBP_SLIDE_EN: reuse the window along a row and
// fetch only the new right column (3 reads) instead of refilling (9 reads).
module lbp_scan_ctrl #(
  parameter int IMG_W  = 128,
  parameter int ADDR_W = 14
) (
  input logic            clk,
  input logic            reset,
  lbp_scan_ctrl_if.master bus
);
  localparam int LW = $clog2(IMG_W);
  localparam logic [LW-1:0] LAST = LW'(IMG_W - 2);

`ifdef LBP_SLIDE_EN
  localparam bit SLIDE = 1'b1;
`else
  localparam bit SLIDE = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_SHIFT, S_WAIT, S_WRITE, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [LW-1:0]     row_q, row_d, col_q, col_d;
  // csel/rsel: window column (0=left..2=right) and row of the pending read
  logic [1:0]        csel_q, csel_d, rsel_q, rsel_d;
  // slot of the read accepted last edge; its data is captured this edge
  logic              pend_q, pend_d;
  logic [1:0]        pc_q, pc_d, pr_q, pr_d;
  logic              gray_req_q, gray_req_d;
  logic [ADDR_W-1:0] gray_addr_q, gray_addr_d;
  logic              lbp_valid_q, lbp_valid_d;
  logic [ADDR_W-1:0] lbp_addr_q, lbp_addr_d;
  logic [7:0]        lbp_data_q, lbp_data_d;
  logic              finish_q, finish_d;
  logic [7:0]        win_q [0:2][0:2];   // [column][row]
  logic [7:0]        code;
  logic              accept;

  assign accept = gray_req_q & bus.gray_ready;

  // Address of window cell (cs, rs) around centre (r, c); power-of-two width
  // makes row*IMG_W+col a plain concatenation.
  function automatic logic [ADDR_W-1:0] mk_addr(input logic [LW-1:0] r,
                                                input logic [LW-1:0] c,
                                                input logic [1:0] cs,
                                                input logic [1:0] rs);
    logic [LW-1:0] rr, cc;
    rr = r + LW'(rs) - LW'(1);
    cc = c + LW'(cs) - LW'(1);
    return {rr, cc};
  endfunction

  // LBP code: neighbour >= centre, bits TL,T,TR,L,R,BL,B,BR from bit 0 up.
  assign code = {win_q[2][2] >= win_q[1][1], win_q[1][2] >= win_q[1][1],
                 win_q[0][2] >= win_q[1][1], win_q[2][1] >= win_q[1][1],
                 win_q[0][1] >= win_q[1][1], win_q[2][0] >= win_q[1][1],
                 win_q[1][0] >= win_q[1][1], win_q[0][0] >= win_q[1][1]};

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    csel_d      = csel_q;
    rsel_d      = rsel_q;
    pend_d      = accept;
    pc_d        = csel_q;
    pr_d        = rsel_q;
    gray_req_d  = gray_req_q;
    gray_addr_d = gray_addr_q;
    lbp_valid_d = 1'b0;
    lbp_addr_d  = lbp_addr_q;
    lbp_data_d  = lbp_data_q;
    finish_d    = finish_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.gray_ready) begin
          state_d     = S_FILL;
          gray_req_d  = 1'b1;
          csel_d      = 2'd0;
          rsel_d      = 2'd0;
          gray_addr_d = mk_addr(row_q, col_q, 2'd0, 2'd0);
        end
      end
      S_FILL, S_SHIFT: begin
        if (accept) begin
          if (csel_q == 2'd2 && rsel_q == 2'd2) begin
            gray_req_d = 1'b0;
            state_d    = S_WAIT;
          end else begin
            if (rsel_q == 2'd2) begin
              rsel_d = 2'd0;
              csel_d = csel_q + 2'd1;
            end else begin
              rsel_d = rsel_q + 2'd1;
            end
            gray_addr_d = mk_addr(row_q, col_q, csel_d, rsel_d);
          end
        end
      end
      // last datum is captured at the edge leaving WAIT
      S_WAIT: state_d = S_WRITE;
      S_WRITE: begin
        lbp_valid_d = 1'b1;
        lbp_addr_d  = {row_q, col_q};
        lbp_data_d  = code;
        if (col_q < LAST) begin
          col_d   = col_q + LW'(1);
          state_d = SLIDE ? S_SHIFT : S_FILL;
        end else if (row_q < LAST) begin
          row_d   = row_q + LW'(1);
          col_d   = LW'(1);
          state_d = S_FILL;
        end else begin
          state_d = S_DONE;
        end
        if (state_d != S_DONE) begin
          gray_req_d  = 1'b1;
          rsel_d      = 2'd0;
          csel_d      = (state_d == S_SHIFT) ? 2'd2 : 2'd0;
          gray_addr_d = mk_addr(row_d, col_d, csel_d, 2'd0);
        end
      end
      S_DONE:  finish_d = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      row_q       <= LW'(1);
      col_q       <= LW'(1);
      csel_q      <= 2'd0;
      rsel_q      <= 2'd0;
      pend_q      <= 1'b0;
      pc_q        <= 2'd0;
      pr_q        <= 2'd0;
      gray_req_q  <= 1'b0;
      gray_addr_q <= '0;
      lbp_valid_q <= 1'b0;
      lbp_addr_q  <= '0;
      lbp_data_q  <= '0;
      finish_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      csel_q      <= csel_d;
      rsel_q      <= rsel_d;
      pend_q      <= pend_d;
      pc_q        <= pc_d;
      pr_q        <= pr_d;
      gray_req_q  <= gray_req_d;
      gray_addr_q <= gray_addr_d;
      lbp_valid_q <= lbp_valid_d;
      lbp_addr_q  <= lbp_addr_d;
      lbp_data_q  <= lbp_data_d;
      finish_q    <= finish_d;
    end
  end

  // Window: slide left when moving to SHIFT, capture returning read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < 3; c++)
        for (int r = 0; r < 3; r++)
          win_q[c][r] <= '0;
    end else begin
      if (state_q == S_WRITE && state_d == S_SHIFT) begin
        for (int r = 0; r < 3; r++) begin
          win_q[0][r] <= win_q[1][r];
          win_q[1][r] <= win_q[2][r];
        end
      end
      if (pend_q) win_q[pc_q][pr_q] <= bus.gray_data;
    end
  end

  assign bus.gray_req  = gray_req_q;
  assign bus.gray_addr = gray_addr_q;
  assign bus.lbp_valid = lbp_valid_q;
  assign bus.lbp_addr  = lbp_addr_q;
  assign bus.lbp_data  = lbp_data_q;
  assign bus.finish    = finish_q;
endmodule

// File: tb/tb_lbp_scan_ctrl.sv
// Testbench for lbp_scan_ctrl on a 16x16 image: a host memory model answers
// reads one cycle after acceptance and every write is compared to a
// neighbourhood-based LBP reference computed directly from the image array.
module tb_lbp_scan_ctrl;
  localparam int W    = 16;
  localparam int AW   = 8;
  localparam int IN   = W - 2;
  localparam int NPIX = IN * IN;
`ifdef LBP_SLIDE_EN
  localparam int EXP_READS = IN * (9 + (IN - 1) * 3);
  localparam int EXP_GAP   = 5;
`else
  localparam int EXP_READS = NPIX * 9;
  localparam int EXP_GAP   = 11;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  lbp_scan_ctrl_if #(.ADDR_W(AW)) bus ();

  lbp_scan_ctrl #(.IMG_W(W), .ADDR_W(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] img [W*W];
  int widx, reads, tcount, first_t, second_t;
  bit prev_valid, cur_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference LBP code of interior pixel (r,c) from the image array.
  function automatic logic [7:0] ref_code(input int r, input int c);
    int dr [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
    int dc [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
    logic [7:0] v;
    v = '0;
    for (int k = 0; k < 8; k++)
      if (img[(r + dr[k]) * W + c + dc[k]] >= img[r * W + c]) v[k] = 1'b1;
    return v;
  endfunction

  // One clock: serve the read accepted at this edge, check held requests,
  // score any write, then pick gray_ready for the next cycle.
  task automatic tick(input int pct);
    bit acc, stall;
    logic [AW-1:0] a;
    int r, c;
    acc   = bus.gray_req && bus.gray_ready;
    stall = bus.gray_req && !bus.gray_ready;
    a     = bus.gray_addr;
    @(posedge clk);
    #1;
    tcount++;
    if (acc) begin
      bus.gray_data = img[a];
      reads++;
    end else begin
      bus.gray_data = 8'($urandom);
    end
    if (stall && !reset) begin
      chk("hold_req", 32'(bus.gray_req), 32'd1);
      chk("hold_addr", 32'(bus.gray_addr), 32'(a));
    end
    prev_valid = cur_valid;
    cur_valid  = bus.lbp_valid;
    if (bus.lbp_valid) begin
      chk("write_in_range", 32'(widx < NPIX), 32'd1);
      if (widx < NPIX) begin
        r = 1 + widx / IN;
        c = 1 + widx % IN;
        chk("lbp_addr", 32'(bus.lbp_addr), 32'(r * W + c));
        chk("lbp_data", 32'(bus.lbp_data), 32'(ref_code(r, c)));
      end
      if (widx == 0) first_t = tcount;
      if (widx == 1) second_t = tcount;
      widx++;
    end
    bus.gray_ready = ($urandom_range(0, 99) < pct);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},    32'(bus.gray_req),  32'd0);
    chk({tag, "_gaddr"},  32'(bus.gray_addr), 32'd0);
    chk({tag, "_valid"},  32'(bus.lbp_valid), 32'd0);
    chk({tag, "_laddr"},  32'(bus.lbp_addr),  32'd0);
    chk({tag, "_ldata"},  32'(bus.lbp_data),  32'd0);
    chk({tag, "_finish"}, 32'(bus.finish),    32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.gray_ready = 1'b0;
    tick(0);
    tick(0);
    chk_reset_outputs("reset");
    reset = 1'b0;
  endtask

  // Run a frame until finish; with stop=1 return while pixel (5,7) is
  // fetching its right column.
  task automatic run_frame(input int pct, input bit stop);
    bit stopped = 1'b0;
    widx = 0; reads = 0; tcount = 0; first_t = -1; second_t = -1;
    prev_valid = 1'b0; cur_valid = 1'b0;
    bus.gray_ready = ($urandom_range(0, 99) < pct);
    for (int i = 0; i < 20000; i++) begin
      if (stop && widx == 4 * IN + 6 && bus.gray_req && bus.gray_addr == AW'(5 * W + 8)) begin
        stopped = 1'b1;
        break;
      end
      tick(pct);
      if (bus.finish) break;
    end
    if (stop) begin
      chk("reset_trigger", 32'(stopped), 32'd1);
    end else begin
      chk("finish_seen", 32'(bus.finish), 32'd1);
      chk("write_count", 32'(widx), 32'(NPIX));
      chk("read_count", 32'(reads), 32'(EXP_READS));
      chk("finish_after_last_write", {30'd0, prev_valid, cur_valid}, 32'd2);
    end
  endtask

  initial begin
    bus.gray_ready = 1'b0;
    bus.gray_data  = '0;
    widx = 0; reads = 0; tcount = 0;
    cur_valid = 1'b0; prev_valid = 1'b0;

    // Reset, then idle with gray_ready low: nothing may move.
    do_reset();
    for (int i = 0; i < 20; i++) tick(0);
    chk_reset_outputs("idle");
    chk("idle_writes", 32'(widx), 32'd0);
    chk("idle_reads", 32'(reads), 32'd0);

    // Uniform image at full rate: all codes 0xFF, fixed latency and pitch.
    for (int i = 0; i < W * W; i++) img[i] = 8'h55;
    run_frame(100, 1'b0);
    chk("first_write_cycle", 32'(first_t), 32'd12);
    chk("write_pitch", 32'(second_t - first_t), 32'(EXP_GAP));
    for (int i = 0; i < 5; i++) tick(100);
    chk("done_req", 32'(bus.gray_req), 32'd0);
    chk("done_valid", 32'(bus.lbp_valid), 32'd0);
    chk("done_finish", 32'(bus.finish), 32'd1);
    chk("done_no_writes", 32'(widx), 32'(NPIX));

    // Ramp image.
    do_reset();
    for (int i = 0; i < W * W; i++) img[i] = 8'(i);
    run_frame(100, 1'b0);

    // Random image with random gray_ready.
    do_reset();
    for (int i = 0; i < W * W; i++) img[i] = 8'($urandom);
    run_frame(50, 1'b0);

    // Random image with few distinct levels (plenty of equal neighbours).
    do_reset();
    for (int i = 0; i < W * W; i++) img[i] = 8'($urandom_range(0, 3));
    run_frame(70, 1'b0);

    // Reset in the middle of pixel (5,7), then a full clean frame.
    do_reset();
    for (int i = 0; i < W * W; i++) img[i] = 8'($urandom);
    run_frame(60, 1'b1);
    reset = 1'b1;
    tick(60);
    chk_reset_outputs("midreset");
    reset = 1'b0;
    run_frame(50, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
